// File: rtl/mem_capture_pkg.sv
// mem_capture_pkg
//   Shared types for the stream-to-memory capture block.
//   - state_t : capture state machine encoding
//   - len_w() : bit width needed to hold a frame length of 0..mem_size
package mem_capture_pkg;

  typedef enum logic [1:0] {
    ST_RECV   = 2'd0,
    ST_DROP   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int len_w(input int mem_size);
    return $clog2(mem_size + 1);
  endfunction

endpackage

// File: rtl/mem_capture_core.sv
// mem_capture_core
//   State machine, write pointer, beat counter and frame status registers
//   of the stream-to-memory capture block.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   s_axis_*            : AXI4-Stream slave (tdata/tlast/tvalid in, tready out)
//   mem_we/addr/wdata   : registered memory write port
//   frame_valid/len/ovf : captured frame status, held until frame_ack
//   frame_ack           : one-cycle release pulse, honoured only in ST_DONE
module mem_capture_core
  import mem_capture_pkg::*;
#(
  parameter int C_MEM_SIZE   = 4,
  parameter int C_DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [C_DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic                            mem_we,
  output logic [$clog2(C_MEM_SIZE)-1:0]   mem_addr,
  output logic [C_DATA_WIDTH-1:0]         mem_wdata,
  output logic                            frame_valid,
  output logic [len_w(C_MEM_SIZE)-1:0]    frame_len,
  output logic                            frame_overflow,
  input  logic                            frame_ack
);

  localparam int AW = $clog2(C_MEM_SIZE);
  localparam int LW = len_w(C_MEM_SIZE);
  localparam logic [AW-1:0] PTR_MAX = AW'(C_MEM_SIZE - 1);
  localparam logic [LW-1:0] CNT_MAX = LW'(C_MEM_SIZE);

  state_t                  state_q, state_d;
  logic                    tready_q, tready_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]           cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    we_q, we_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                    fv_q, fv_d;
  logic [LW-1:0]           len_q, len_d;
  logic                    fovf_q, fovf_d;
  logic                    accept;

  // Internal handshake uses the registered ready, so nothing is accepted
  // while reset is asserted even though tready is shown high to the source.
  assign accept        = s_axis_tvalid & tready_q;
  assign s_axis_tready = tready_q | ~rst_n;

  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign frame_valid    = fv_q;
  assign frame_len      = len_q;
  assign frame_overflow = fovf_q;

  always_comb begin
    state_d  = state_q;
    tready_d = tready_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fv_d     = fv_q;
    len_d    = len_q;
    fovf_d   = fovf_q;
    case (state_q)
      ST_RECV: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = wr_ptr_q;
          wdata_d = s_axis_tdata;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          // Pointer parks on the last address instead of wrapping.
          if (wr_ptr_q != PTR_MAX) wr_ptr_d = wr_ptr_q + 1'b1;
          if (s_axis_tlast) begin
            state_d  = ST_COMMIT;
            tready_d = 1'b0;
          end else if (wr_ptr_q == PTR_MAX) begin
            // Memory is full and more beats follow: the tail is discarded.
            ovf_d   = 1'b1;
            state_d = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (accept && s_axis_tlast) begin
          state_d  = ST_COMMIT;
          tready_d = 1'b0;
        end
      end
      ST_COMMIT: begin
        // frame_valid rises on the same edge the final word is written.
        fv_d    = 1'b1;
        len_d   = cnt_q;
        fovf_d  = ovf_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (frame_ack) begin
          fv_d     = 1'b0;
          fovf_d   = 1'b0;
          ovf_d    = 1'b0;
          wr_ptr_d = '0;
          cnt_d    = '0;
          tready_d = 1'b1;
          state_d  = ST_RECV;
        end
      end
      default: begin
        state_d  = ST_RECV;
        tready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RECV;
      tready_q <= 1'b1;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      fv_q     <= 1'b0;
      len_q    <= '0;
      fovf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tready_q <= tready_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      fv_q     <= fv_d;
      len_q    <= len_d;
      fovf_q   <= fovf_d;
    end
  end

endmodule

// File: rtl/mem_capture.sv
// mem_capture
//   AXI4-Stream slave that writes one frame into a single-port memory from
//   address 0, reports its length/overflow and stalls until frame_ack.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   s_axis_*                : stream slave input
//   mem_clk/rst/en/we/addr/wdata : memory write port (clk/rst passed through)
//   frame_valid/len/overflow, frame_ack : frame status and release
module mem_capture
  import mem_capture_pkg::*;
#(
  parameter int C_MEM_SIZE   = 4,
  parameter int C_DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [C_DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic                            mem_clk,
  output logic                            mem_rst,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [$clog2(C_MEM_SIZE)-1:0]   mem_addr,
  output logic [C_DATA_WIDTH-1:0]         mem_wdata,
  output logic                            frame_valid,
  output logic [len_w(C_MEM_SIZE)-1:0]    frame_len,
  output logic                            frame_overflow,
  input  logic                            frame_ack
);

  assign mem_clk = clk;
  assign mem_rst = rst;
  assign mem_en  = mem_we;

  mem_capture_core #(
    .C_MEM_SIZE   (C_MEM_SIZE),
    .C_DATA_WIDTH (C_DATA_WIDTH)
  ) u_core (
    .clk            (clk),
    .rst_n          (~rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .frame_valid    (frame_valid),
    .frame_len      (frame_len),
    .frame_overflow (frame_overflow),
    .frame_ack      (frame_ack)
  );

endmodule

// File: doc/mem_capture.md
# mem_capture

Stream-to-memory capture block: an AXI4-Stream slave that writes each accepted beat of one frame into a single-port memory (DRAM/BRAM write port), starting at address 0. It reports the captured frame length and an overflow flag, then holds off the stream until software or a downstream consumer acknowledges the frame. It is the writer counterpart of `mem_streamer`, which reads memory and emits a stream. Together they let a frame be captured on one side and replayed on the other.

## Interface

Parameters:

- `C_MEM_SIZE`, 4: memory depth in words; maximum frame length in beats. Must be ≥ 2.
- `C_DATA_WIDTH`, 8: word and `tdata` width in bits.

Ports:

- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous, active-high.
- `s_axis_tdata` in `C_DATA_WIDTH`: stream data.
- `s_axis_tlast` in 1: last beat of frame.
- `s_axis_tvalid` in 1: beat valid.
- `s_axis_tready` out 1: beat accepted when `tvalid & tready`.
- `mem_clk` out 1: equal to `clk`.
- `mem_rst` out 1: equal to `rst`.
- `mem_en` out 1: memory enable; equal to `mem_we`.
- `mem_we` out 1: write strobe, registered.
- `mem_addr` out `$clog2(C_MEM_SIZE)`: write address, registered.
- `mem_wdata` out `C_DATA_WIDTH`: write data, registered.
- `frame_valid` out 1: a captured frame is ready; held high until acknowledged.
- `frame_len` out `$clog2(C_MEM_SIZE+1)`: number of words stored, 1..`C_MEM_SIZE`; valid while `frame_valid` is high.
- `frame_overflow` out 1: the frame exceeded `C_MEM_SIZE` beats and its tail was discarded; valid while `frame_valid` is high.
- `frame_ack` in 1: single-cycle pulse that releases the frame.

## Operation

The block is a state machine with three working states plus a one-cycle commit state:

- `ST_RECV`: `tready`=1. Each accepted beat is written to `wr_ptr`, then `wr_ptr` increments.
  - Accepted beat with `tlast`=1: go to `ST_COMMIT`.
  - Accepted beat with `tlast`=0 at `wr_ptr`=`C_MEM_SIZE`-1: this beat is written, `overflow`←1, go to `ST_DROP`.
- `ST_DROP`: `tready`=1. Beats are accepted but not written. An accepted `tlast` beat goes to `ST_COMMIT`.
- `ST_COMMIT` (one cycle): `tready`=0. `frame_valid`←1 and `frame_len`←count of words written. Go to `ST_DONE`.
- `ST_DONE`: `tready`=0. On `frame_ack`=1: clear `frame_valid`, `frame_overflow` and `wr_ptr`, then go to `ST_RECV`.

`frame_ack` is ignored in every state other than `ST_DONE`.

Boundary cases:

- A beat that is both the `C_MEM_SIZE`-th beat and carries `tlast` is exactly full. It is not an overflow: `frame_len`=`C_MEM_SIZE`, `frame_overflow`=0.
- A zero-length frame is impossible, because every frame contains at least its `tlast` beat.
- `wr_ptr` never wraps. Writes stop at address `C_MEM_SIZE`-1.
- The beat counter saturates at `C_MEM_SIZE`.
- `rst` asserted mid-frame abandons the partial frame: the state returns to `ST_RECV`, no `frame_valid` is raised, and any pending write strobe is cleared.

Reset values:

- State `ST_RECV`, `s_axis_tready`=1.
- `mem_we`=`mem_en`=0, `mem_addr`=0, `mem_wdata`=0.
- `frame_valid`=0, `frame_len`=0, `frame_overflow`=0.
- `tready` is driven high during reset. No beat is accepted while `rst`=1.

## Timing

- Beat accepted at edge N: `mem_we`=1 with its `mem_addr` and `mem_wdata` during cycle N→N+1, and the memory captures the word at edge N+1.
- Last beat accepted at edge N:
  - `tready` drops from cycle N onward (`ST_COMMIT`).
  - `frame_valid` rises at edge N+1, the same edge at which the last word is written.
  - The first read of memory by the consumer at edge N+2 or later returns the completed data.
- Back-to-back beats are sustained at one beat per cycle in `ST_RECV` and `ST_DROP`, with no bubbles.
- `frame_ack` sampled high at edge M in `ST_DONE`: `frame_valid`=0 and `tready`=1 from edge M onward. A beat may be accepted at edge M+1.

## Structure

- Package `mem_capture_pkg`: state enum (`ST_RECV`, `ST_DROP`, `ST_COMMIT`, `ST_DONE`) and a width helper for `frame_len`.
- One natural sub-module, `mem_capture_core`: the state machine, counters and status registers, with a `rst_n` port.
- Thin top `mem_capture`: drives `mem_clk`/`mem_rst`/`mem_en` and inverts `rst` to feed `mem_capture_core`, the same pattern as the existing stream wrappers.

## Test plan

- **Nominal:** `C_MEM_SIZE`=4, 3 beats 0xA1, 0xA2, 0xA3 with `tlast` on 0xA3. Expect writes at addresses 0/1/2 with those data, then `frame_valid`=1, `frame_len`=3, `frame_overflow`=0.
- **Exact full:** 4 beats with `tlast` on the 4th. Expect 4 writes (addresses 0–3), `frame_len`=4, `frame_overflow`=0.
- **Overflow:** 7 beats 0x10..0x16 with `tlast` on the 7th. Expect only 0x10..0x13 written to addresses 0..3, all 7 beats accepted, `frame_len`=4, `frame_overflow`=1.
- **Hold-off and ack:** with `frame_valid`=1, hold `tvalid`=1 for 10 cycles. Expect `tready`=0 and no `mem_we`. Pulse `frame_ack`. Expect `tready`=1 next cycle, and the next frame writes from address 0.
- **Bubbles and single-beat frame:** random `tvalid` gaps produce the correct address sequence with no duplicate writes. A 1-beat frame gives `frame_len`=1.
- **Reset mid-frame:** assert `rst` after 2 of 3 beats, release, then send a new 2-beat frame. Expect `frame_len`=2 and addresses 0 and 1 rewritten.
